// File: rtl/pipe_funnel_tx_if.sv
// pipe_funnel_tx_if: enq-style pipe bundle for the message funnel.
//   Upstream pipe   : in_enq_ena / in_enq_v   -> in_enq_rdy
//   Downstream pipe : out_enq_ena / out_enq_v / out_enq_last <- out_enq_rdy
// Modports:
//   slave  - the funnel itself (accepts messages, produces beats)
//   master - the environment (offers messages, sinks beats)
interface pipe_funnel_tx_if #(
   parameter int DATA_WIDTH   = 144,
   parameter int FUNNEL_WIDTH = 32
);
   logic                    in_enq_ena;
   logic [DATA_WIDTH-1:0]   in_enq_v;
   logic                    in_enq_rdy;
   logic                    out_enq_ena;
   logic [FUNNEL_WIDTH-1:0] out_enq_v;
   logic                    out_enq_last;
   logic                    out_enq_rdy;

   modport slave (
      input  in_enq_ena, in_enq_v, out_enq_rdy,
      output in_enq_rdy, out_enq_ena, out_enq_v, out_enq_last
   );

   modport master (
      output in_enq_ena, in_enq_v, out_enq_rdy,
      input  in_enq_rdy, out_enq_ena, out_enq_v, out_enq_last
   );
endinterface

// File: rtl/pipe_funnel_tx.sv
// pipe_funnel_tx: buffers up to two DATA_WIDTH-bit messages and emits each
// as BEATS beats of FUNNEL_WIDTH bits, least-significant beat first.
// Ports:
//   CLK   - clock, all state on rising edge
//   nRST  - asynchronous active-low reset
//   bus   - pipe_funnel_tx_if.slave (upstream message pipe, downstream beat pipe)
//   busy  - at least one message is buffered or being serialised
//
// Handshake: a transfer happens in any cycle where ENA=1; ENA is only legal
// while the matching RDY=1. in_enq_rdy depends on registered state only.
// out_enq_ena is (message available) && out_enq_rdy, so the sink's RDY
// is the only combinational path through the block.
module pipe_funnel_tx #(
   parameter int DATA_WIDTH   = 144,
   parameter int FUNNEL_WIDTH = 32
) (
   input  logic                  CLK,
   input  logic                  nRST,
   pipe_funnel_tx_if.slave       bus,
   output logic                  busy
);
   localparam int         BEATS    = (DATA_WIDTH + FUNNEL_WIDTH - 1) / FUNNEL_WIDTH;
   localparam int         PAD_W    = BEATS * FUNNEL_WIDTH;
   localparam logic [2:0] LAST_IDX = 3'(BEATS - 1);

   logic [DATA_WIDTH-1:0] fifo_mem [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            count;
   logic [2:0]            idx;

   logic                  has_msg;
   logic                  enq;
   logic                  beat_xfer;
   logic                  last_xfer;
   logic [PAD_W-1:0]      head_pad;

   assign has_msg   = (count != 2'd0);
   assign enq       = bus.in_enq_ena && bus.in_enq_rdy;
   assign beat_xfer = has_msg && bus.out_enq_rdy;
   assign last_xfer = beat_xfer && (idx == LAST_IDX);

   // Zero-extend the head message so the top beat reads 0 above DATA_WIDTH.
   always_comb begin
      head_pad                 = '0;
      head_pad[DATA_WIDTH-1:0] = fifo_mem[rd_ptr];
   end

   assign bus.in_enq_rdy   = (count < 2'd2);
   assign bus.out_enq_ena  = beat_xfer;
   // Gated by has_msg so the beat bus is 0 when empty and during reset,
   // regardless of stale storage contents.
   assign bus.out_enq_v    = has_msg ? head_pad[int'(idx) * FUNNEL_WIDTH +: FUNNEL_WIDTH]
                                     : '0;
   assign bus.out_enq_last = has_msg && (idx == LAST_IDX);
   assign busy             = has_msg;

   // Message storage needs no reset: it is never observed while count==0.
   always_ff @(posedge CLK) begin
      if (enq) begin
         fifo_mem[wr_ptr] <= bus.in_enq_v;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         idx    <= 3'd0;
      end else begin
         if (enq) begin
            wr_ptr <= ~wr_ptr;
         end
         if (beat_xfer) begin
            if (idx == LAST_IDX) begin
               idx    <= 3'd0;
               rd_ptr <= ~rd_ptr;
            end else begin
               idx <= idx + 3'd1;
            end
         end
         // Enqueue together with a final-beat dequeue leaves count unchanged.
         if (enq && !last_xfer) begin
            count <= count + 2'd1;
         end else if (!enq && last_xfer) begin
            count <= count - 2'd1;
         end
      end
   end

   // Upstream must not strobe ENA while the buffer is full.
   enq_while_full: assert property (@(posedge CLK) disable iff (!nRST)
      !(bus.in_enq_ena && !bus.in_enq_rdy));

endmodule

// File: tb/tb_pipe_funnel_tx.sv
// tb_pipe_funnel_tx: directed table-driven bench for pipe_funnel_tx, plus a
// hand-written mid-message reset sequence.
module tb_pipe_funnel_tx;
   localparam int DW = 144;
   localparam int FW = 32;

   localparam logic [DW-1:0] MSG_A = 144'hABCD_00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [DW-1:0] MSG_B = 144'h5A5A_11111111_22222222_33333333_44444444;
   localparam logic [DW-1:0] MSG_C = 144'hC3C3_DEADBEEF_CAFEF00D_01234567_89ABCDEF;

   typedef struct {
      logic          in_ena;
      logic [DW-1:0] in_v;
      logic          out_rdy;
      logic          exp_in_rdy;
      logic          exp_out_ena;
      logic [FW-1:0] exp_v;
      logic          exp_last;
      logic          exp_busy;
   } vec_t;

   logic clk;
   logic rst_n;
   logic busy;
   int   checks;
   int   errors;
   vec_t vecs[$];

   pipe_funnel_tx_if #(.DATA_WIDTH(DW), .FUNNEL_WIDTH(FW)) bus ();

   pipe_funnel_tx #(.DATA_WIDTH(DW), .FUNNEL_WIDTH(FW)) dut (
      .CLK  (clk),
      .nRST (rst_n),
      .bus  (bus),
      .busy (busy)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- driver / checker tasks ----------------
   task automatic add(input logic ena, input logic [DW-1:0] v, input logic ordy,
                      input logic erdy, input logic eena, input logic [FW-1:0] ev,
                      input logic elast, input logic ebusy);
      vec_t r;
      r.in_ena = ena;   r.in_v = v;          r.out_rdy = ordy;
      r.exp_in_rdy = erdy; r.exp_out_ena = eena; r.exp_v = ev;
      r.exp_last = elast;  r.exp_busy = ebusy;
      vecs.push_back(r);
   endtask

   task automatic chk(input string name, input int row, input logic [FW-1:0] act,
                      input logic [FW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   task automatic chk_outputs(input int row, input logic erdy, input logic eena,
                              input logic [FW-1:0] ev, input logic elast,
                              input logic ebusy);
      chk("in_rdy",  row, FW'(bus.in_enq_rdy),   FW'(erdy));
      chk("out_ena", row, FW'(bus.out_enq_ena),  FW'(eena));
      chk("out_v",   row, bus.out_enq_v,         ev);
      chk("out_last",row, FW'(bus.out_enq_last), FW'(elast));
      chk("busy",    row, FW'(busy),             FW'(ebusy));
   endtask

   task automatic drive(input logic ena, input logic [DW-1:0] v, input logic ordy);
      bus.in_enq_ena  = ena;
      bus.in_enq_v    = v;
      bus.out_enq_rdy = ordy;
   endtask

   // ---------------- test ----------------
   logic [FW-1:0] c_beats [5];

   initial begin
      checks = 0;
      errors = 0;
      c_beats = '{32'h89ABCDEF, 32'h01234567, 32'hCAFEF00D, 32'hDEADBEEF, 32'h0000C3C3};
      rst_n = 1'b0;
      drive(1'b0, '0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk_outputs(-1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // Single message A, sink always ready.
      add(0, '0,    1, 1, 0, 32'h0,        0, 0);
      add(1, MSG_A, 1, 1, 0, 32'h0,        0, 0);
      add(0, '0,    1, 1, 1, 32'hCCDDEEFF, 0, 1);
      add(0, '0,    1, 1, 1, 32'h8899AABB, 0, 1);
      add(0, '0,    1, 1, 1, 32'h44556677, 0, 1);
      add(0, '0,    1, 1, 1, 32'h00112233, 0, 1);
      add(0, '0,    1, 1, 1, 32'h0000ABCD, 1, 1);
      add(0, '0,    1, 1, 0, 32'h0,        0, 0);
      // Three back-to-back messages B, C, A; A waits for a free slot.
      add(1, MSG_B, 1, 1, 0, 32'h0,        0, 0);
      add(1, MSG_C, 1, 1, 1, 32'h44444444, 0, 1);
      add(0, '0,    1, 0, 1, 32'h33333333, 0, 1);
      add(0, '0,    1, 0, 1, 32'h22222222, 0, 1);
      add(0, '0,    1, 0, 1, 32'h11111111, 0, 1);
      add(0, '0,    1, 0, 1, 32'h00005A5A, 1, 1);
      add(1, MSG_A, 1, 1, 1, 32'h89ABCDEF, 0, 1);
      add(0, '0,    1, 0, 1, 32'h01234567, 0, 1);
      add(0, '0,    1, 0, 1, 32'hCAFEF00D, 0, 1);
      add(0, '0,    1, 0, 1, 32'hDEADBEEF, 0, 1);
      add(0, '0,    1, 0, 1, 32'h0000C3C3, 1, 1);
      add(0, '0,    1, 1, 1, 32'hCCDDEEFF, 0, 1);
      add(0, '0,    1, 1, 1, 32'h8899AABB, 0, 1);
      add(0, '0,    1, 1, 1, 32'h44556677, 0, 1);
      add(0, '0,    1, 1, 1, 32'h00112233, 0, 1);
      add(0, '0,    1, 1, 1, 32'h0000ABCD, 1, 1);
      add(0, '0,    1, 1, 0, 32'h0,        0, 0);
      // Sink stalls mid-message: beats hold, none lost or repeated.
      add(1, MSG_B, 1, 1, 0, 32'h0,        0, 0);
      add(0, '0,    1, 1, 1, 32'h44444444, 0, 1);
      add(0, '0,    0, 1, 0, 32'h33333333, 0, 1);
      add(0, '0,    0, 1, 0, 32'h33333333, 0, 1);
      add(0, '0,    1, 1, 1, 32'h33333333, 0, 1);
      add(0, '0,    0, 1, 0, 32'h22222222, 0, 1);
      add(0, '0,    0, 1, 0, 32'h22222222, 0, 1);
      add(0, '0,    1, 1, 1, 32'h22222222, 0, 1);
      add(0, '0,    1, 1, 1, 32'h11111111, 0, 1);
      add(0, '0,    0, 1, 0, 32'h00005A5A, 1, 1);
      add(0, '0,    1, 1, 1, 32'h00005A5A, 1, 1);
      add(0, '0,    1, 1, 0, 32'h0,        0, 0);
      // Enqueue A in the same cycle as C's final beat at count=1.
      add(1, MSG_C, 1, 1, 0, 32'h0,        0, 0);
      add(0, '0,    1, 1, 1, 32'h89ABCDEF, 0, 1);
      add(0, '0,    1, 1, 1, 32'h01234567, 0, 1);
      add(0, '0,    1, 1, 1, 32'hCAFEF00D, 0, 1);
      add(0, '0,    1, 1, 1, 32'hDEADBEEF, 0, 1);
      add(1, MSG_A, 1, 1, 1, 32'h0000C3C3, 1, 1);
      add(0, '0,    1, 1, 1, 32'hCCDDEEFF, 0, 1);
      add(0, '0,    1, 1, 1, 32'h8899AABB, 0, 1);
      add(0, '0,    1, 1, 1, 32'h44556677, 0, 1);
      add(0, '0,    1, 1, 1, 32'h00112233, 0, 1);
      add(0, '0,    1, 1, 1, 32'h0000ABCD, 1, 1);
      add(0, '0,    1, 1, 0, 32'h0,        0, 0);

      @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].in_ena, vecs[i].in_v, vecs[i].out_rdy);
         @(negedge clk);
         chk_outputs(i, vecs[i].exp_in_rdy, vecs[i].exp_out_ena, vecs[i].exp_v,
                     vecs[i].exp_last, vecs[i].exp_busy);
         @(posedge clk);
         #1;
      end

      // Mid-message reset between beats 2 and 3 of B.
      drive(1'b1, MSG_B, 1'b1);
      @(posedge clk);
      #1;
      drive(1'b0, '0, 1'b1);
      @(negedge clk);
      chk("rst_seq_b0", 100, bus.out_enq_v, 32'h44444444);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_seq_b1", 101, bus.out_enq_v, 32'h33333333);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_seq_b2", 102, bus.out_enq_v, 32'h22222222);
      @(posedge clk);
      #1;
      chk("rst_seq_b3", 103, bus.out_enq_v, 32'h11111111);
      rst_n = 1'b0;
      #1;
      chk_outputs(104, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk_outputs(105, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      rst_n = 1'b1;
      drive(1'b1, MSG_C, 1'b1);
      @(posedge clk);
      #1;
      drive(1'b0, '0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_rst_v",    110 + i, bus.out_enq_v, c_beats[i]);
         chk("post_rst_last", 110 + i, FW'(bus.out_enq_last), FW'(i == 4));
         chk("post_rst_ena",  110 + i, FW'(bus.out_enq_ena), 32'h1);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("post_rst_busy", 115, FW'(busy), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
